// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup, one update per cycle,
// per-entry saturating direction counter and per-set round-robin replacement.
module btb_assoc #(
  parameter int XLEN  = 32,
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            update,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            invalidate_all,
  output logic [XLEN-1:0] target_pc,
  output logic            valid,
  output logic            predicted_taken,
  output logic [1:0]      hit_way
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WAYS - 1);

  logic             r_valid [SETS][WAYS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [XLEN-1:0]  r_tgt   [SETS][WAYS];
  logic [CNT_W-1:0] r_cnt   [SETS][WAYS];
  logic [PTR_W-1:0] r_ptr   [SETS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [PTR_W-1:0] w_way;

  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [PTR_W-1:0] w_u_way;
  logic             w_inv_found;
  logic [PTR_W-1:0] w_inv_way;
  logic [PTR_W-1:0] w_victim;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_unused;
  assign w_unused = ^{pc[1:0], update_pc[1:0]};

  assign w_idx   = pc[IDX_W+1:2];
  assign w_tag   = pc[XLEN-1:IDX_W+2];
  assign w_u_idx = update_pc[IDX_W+1:2];
  assign w_u_tag = update_pc[XLEN-1:IDX_W+2];

  // Descending scans so the lowest-numbered match wins.
  always_comb begin
    w_hit = 1'b0;
    w_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit = 1'b1;
        w_way = PTR_W'(w);
      end
    end
  end

  always_comb begin
    w_u_hit     = 1'b0;
    w_u_way     = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
        w_u_hit = 1'b1;
        w_u_way = PTR_W'(w);
      end
      if (!r_valid[w_u_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = PTR_W'(w);
      end
    end
  end

  assign w_victim  = w_inv_found ? w_inv_way : r_ptr[w_u_idx];
  assign w_ptr_nxt = (r_ptr[w_u_idx] == PTR_LAST) ? '0 : r_ptr[w_u_idx] + PTR_W'(1);

  always_comb begin
    w_cnt_cur = r_cnt[w_u_idx][w_u_way];
    w_cnt_nxt = w_cnt_cur;
    if (update_taken) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_nxt = w_cnt_cur + CNT_W'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_nxt = w_cnt_cur - CNT_W'(1);
    end
  end

  assign valid           = w_hit;
  assign predicted_taken = w_hit & r_cnt[w_idx][w_way][CNT_W-1];
  assign hit_way         = w_hit ? 2'(w_way) : 2'd0;
  assign target_pc       = w_hit ? r_tgt[w_idx][w_way] : pc + XLEN'(4);

  // Invalidate only drops valid bits and pointers; targets and counters persist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_tgt[s][w]   <= '0;
          r_cnt[s][w]   <= '0;
        end
      end
    end else if (invalidate_all) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
        end
      end
    end else if (update) begin
      if (w_u_hit) begin
        r_cnt[w_u_idx][w_u_way] <= w_cnt_nxt;
        if (update_taken) r_tgt[w_u_idx][w_u_way] <= update_target;
      end else if (update_taken) begin
        r_valid[w_u_idx][w_victim] <= 1'b1;
        r_tag[w_u_idx][w_victim]   <= w_u_tag;
        r_tgt[w_u_idx][w_victim]   <= update_target;
        r_cnt[w_u_idx][w_victim]   <= CNT_INIT;
        if (!w_inv_found) r_ptr[w_u_idx] <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (default parameters: XLEN=32, SETS=16, WAYS=2, CNT_W=2).
module tb_btb_assoc;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        invalidate_all;
  logic [31:0] target_pc;
  logic        valid;
  logic        predicted_taken;
  logic [1:0]  hit_way;

  int n_chk  = 0;
  int n_pass = 0;

  btb_assoc #(.XLEN(32), .SETS(16), .WAYS(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .update(update), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .invalidate_all(invalidate_all), .target_pc(target_pc), .valid(valid),
    .predicted_taken(predicted_taken), .hit_way(hit_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic probe(input string tag, input logic [31:0] addr, input logic v,
                       input logic pt, input logic [1:0] hw, input logic [31:0] tgt);
    pc = addr;
    #1;
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".taken"}, 32'(predicted_taken), 32'(pt));
    check({tag, ".way"}, 32'(hit_way), 32'(hw));
    check({tag, ".target"}, target_pc, tgt);
  endtask

  task automatic upd(input logic [31:0] addr, input logic [31:0] tgt, input logic tk);
    update        = 1'b1;
    update_pc     = addr;
    update_target = tgt;
    update_taken  = tk;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pc = 32'h100; update = 1'b0; update_pc = '0;
    update_target = '0; update_taken = 1'b0; invalidate_all = 1'b0;
    #1;
    check("in_reset.valid", 32'(valid), 32'd0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    probe("reset", 32'h100, 1'b0, 1'b0, 2'd0, 32'h104);

    // Allocate: counter starts weakly taken (2).
    upd(32'h100, 32'h200, 1'b1);
    probe("alloc", 32'h100, 1'b1, 1'b1, 2'd0, 32'h200);
    probe("low_bits", 32'h102, 1'b1, 1'b1, 2'd0, 32'h200);

    // Not-taken keeps target; counter 2->1->0 then stays at 0.
    upd(32'h100, 32'h999, 1'b0);
    probe("nt1", 32'h100, 1'b1, 1'b0, 2'd0, 32'h200);
    upd(32'h100, 32'h999, 1'b0);
    probe("nt2", 32'h100, 1'b1, 1'b0, 2'd0, 32'h200);
    upd(32'h100, 32'h999, 1'b0);
    upd(32'h100, 32'h240, 1'b1);
    upd(32'h100, 32'h250, 1'b1);
    probe("sat_low", 32'h100, 1'b1, 1'b1, 2'd0, 32'h250);

    // Counter 2->3->3 then two not-taken -> 1.
    upd(32'h100, 32'h250, 1'b1);
    upd(32'h100, 32'h250, 1'b1);
    upd(32'h100, 32'h999, 1'b0);
    upd(32'h100, 32'h999, 1'b0);
    probe("sat_high", 32'h100, 1'b1, 1'b0, 2'd0, 32'h250);

    upd(32'h500, 32'h777, 1'b0);
    probe("miss_nt", 32'h500, 1'b0, 1'b0, 2'd0, 32'h504);

    // Set 0 replacement: 0x100 hit (cnt 2), 0x140 -> way1, 0x180 evicts way0.
    upd(32'h100, 32'h200, 1'b1);
    upd(32'h140, 32'h400, 1'b1);
    upd(32'h180, 32'h480, 1'b1);
    probe("evicted", 32'h100, 1'b0, 1'b0, 2'd0, 32'h104);
    probe("way1", 32'h140, 1'b1, 1'b1, 2'd1, 32'h400);
    probe("way0", 32'h180, 1'b1, 1'b1, 2'd0, 32'h480);

    upd(32'h1C0, 32'h500, 1'b1);
    probe("rr_evict", 32'h140, 1'b0, 1'b0, 2'd0, 32'h144);
    probe("rr_new", 32'h1C0, 1'b1, 1'b1, 2'd1, 32'h500);

    // Same-cycle lookup sees pre-edge state.
    pc = 32'h300;
    update = 1'b1; update_pc = 32'h300; update_target = 32'h600; update_taken = 1'b1;
    #1;
    check("same_cycle.valid", 32'(valid), 32'd0);
    check("same_cycle.target", target_pc, 32'h304);
    @(posedge clk); #1;
    update = 1'b0;
    probe("after_edge", 32'h300, 1'b1, 1'b1, 2'd0, 32'h600);

    upd(32'h104, 32'h700, 1'b1);
    probe("set1", 32'h104, 1'b1, 1'b1, 2'd0, 32'h700);

    // Invalidate beats a simultaneous update.
    invalidate_all = 1'b1;
    upd(32'h800, 32'h880, 1'b1);
    invalidate_all = 1'b0;
    probe("inv_upd", 32'h800, 1'b0, 1'b0, 2'd0, 32'h804);
    probe("inv_300", 32'h300, 1'b0, 1'b0, 2'd0, 32'h304);
    probe("inv_104", 32'h104, 1'b0, 1'b0, 2'd0, 32'h108);

    // Pointer cleared by invalidate: third allocation in set 0 replaces way0.
    upd(32'h100, 32'h210, 1'b1);
    upd(32'h140, 32'h410, 1'b1);
    upd(32'h180, 32'h490, 1'b1);
    probe("ptr_clr", 32'h180, 1'b1, 1'b1, 2'd0, 32'h490);
    probe("ptr_keep", 32'h140, 1'b1, 1'b1, 2'd1, 32'h410);

    probe("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 2'd0, 32'h0000_0000);

    // Reset across an update edge: nothing written, everything cleared.
    update = 1'b1; update_pc = 32'h900; update_target = 32'h990; update_taken = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    update = 1'b0;
    #2 rst = 1'b1;
    probe("rst_upd", 32'h900, 1'b0, 1'b0, 2'd0, 32'h904);
    probe("rst_clr", 32'h140, 1'b0, 1'b0, 2'd0, 32'h144);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
